uart_rx_fifo: RTL

- Receive-side FIFO of the 16550 UART, directly downstream of the receiver shifter.
- Captures each received character together with its per-character line-status bits (pe, fe, bi) on the receiver's single-cycle push strobe.
- Presents the oldest entry to the RBR/LSR read logic and generates overrun, error-in-FIFO (LSR[7]) and trigger-level status for the interrupt logic.

---
 rtl/uart_rx_fifo.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO of the 16550 UART. It holds each received character together
// with its pe/fe/bi flags. The oldest entry is presented first-word-fall-through
// to the RBR/LSR read logic. The FIFO also provides the overrun,
// error-in-FIFO and trigger-level status used by the interrupt logic.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [1:0]    trig_lvl,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pe_in,
  input  logic          fe_in,
  input  logic          bi_in,
  input  logic          pop,
  input  logic          ovr_clr,
  output logic [7:0]    dout,
  output logic          pe_out,
  output logic          fe_out,
  output logic          bi_out,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          err_in_fifo,
  output logic          trig_hit
);

  // Entry layout: {bi, fe, pe, data}
  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   cnt, err_cnt;
  logic          ovr, en_d;

  logic [10:0]   head;
  logic          head_err, push_err;
  logic          flush, pop_ok, push_ok, ovr_set;
  logic [AW:0]   eff_depth, thr;

  // In 16450 mode (deep = 0) both pointers stay pinned at slot 0.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p, input logic deep);
    return deep ? p + AW'(1) : '0;
  endfunction

  assign head      = mem[rd_ptr];
  assign head_err  = |head[10:8];
  assign push_err  = pe_in | fe_in | bi_in;

  // A change of FIFO mode discards the contents, the same as an FCR flush.
  assign flush     = clr | (en != en_d);
  assign eff_depth = en_d ? (AW+1)'(DEPTH) : (AW+1)'(1);

  assign empty     = (cnt == '0);
  assign full      = (cnt == eff_depth);
  // A pop in the same cycle frees the slot, so a push to a full FIFO is not an overrun.
  assign pop_ok    = pop & ~empty;
  assign push_ok   = push & (~full | pop_ok);
  assign ovr_set   = ~flush & push & full & ~pop_ok;

  assign dout      = empty ? 8'h00 : head[7:0];
  assign pe_out    = ~empty & head[8];
  assign fe_out    = ~empty & head[9];
  assign bi_out    = ~empty & head[10];
  assign count       = cnt;
  assign overrun     = ovr;
  assign err_in_fifo = (err_cnt != '0);

  // Trigger threshold from FCR[7:6]; non-FIFO mode always interrupts on one character.
  always_comb begin
    thr = (AW+1)'(1);
    if (en) begin
      case (trig_lvl)
        2'b00:   thr = (AW+1)'(1);
        2'b01:   thr = (AW+1)'(4);
        2'b10:   thr = (AW+1)'(8);
        default: thr = (AW+1)'(14);
      endcase
    end
  end

  assign trig_hit = (cnt >= thr);

  // Character storage; unreset, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (!flush && push_ok)
      mem[wr_ptr] <= {bi_in, fe_in, pe_in, din};
  end

  // Pointer, occupancy and error-count bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      err_cnt <= '0;
      en_d    <= 1'b0;
    end else begin
      en_d <= en;
      if (flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        cnt     <= '0;
        err_cnt <= '0;
      end else begin
        if (push_ok) wr_ptr <= ptr_inc(wr_ptr, en_d);
        if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr, en_d);
        case ({push_ok, pop_ok})
          2'b10:   cnt <= cnt + (AW+1)'(1);
          2'b01:   cnt <= cnt - (AW+1)'(1);
          default: cnt <= cnt;
        endcase
        case ({push_ok & push_err, pop_ok & head_err})
          2'b10:   err_cnt <= err_cnt + (AW+1)'(1);
          2'b01:   err_cnt <= err_cnt - (AW+1)'(1);
          default: err_cnt <= err_cnt;
        endcase
      end
    end
  end

  // Sticky overrun flag: a new overrun wins over a coincident LSR read.
  always_ff @(posedge clk) begin
    if (rst)          ovr <= 1'b0;
    else if (ovr_set) ovr <= 1'b1;
    else if (ovr_clr) ovr <= 1'b0;
  end

endmodule
